// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   - FSM state encodings (2-bit)
//   - NOP instruction (addi x0,x0,0) presented on reset / misaligned packets
//   - default reset vector
//   - align_word(): clears the byte-offset bits of an address
// Optional feature macro used by the fetch files: FETCH_MISALIGN_CHK_EN
package fetch_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: combinational next-PC select and incrementer.
// Priority: flush target, then (when the held packet is consumed) jump
// target or pc+4, otherwise hold the current pc.
// Ports:
//   i_pc          current fetch pc
//   i_flush       redirect request, i_flush_addr its target
//   i_adv         held packet is being consumed this cycle
//   i_jump_sel    taken jump for the consumed packet, i_jump_addr its target
//   o_pc_nxt      pc to load at the next rising edge
//   o_pc_plus4    i_pc + 4 (wraps modulo 2^32)
// Macro FETCH_MISALIGN_CHK_EN: when undefined, every loaded pc is forced
// word-aligned here; when defined, the raw target is passed through so the
// fetch FSM can flag it.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  input  logic [31:0] i_flush_addr,
  input  logic        i_adv,
  input  logic        i_jump_sel,
  input  logic [31:0] i_jump_addr,
  output logic [31:0] o_pc_nxt,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] w_sel;

  assign o_pc_plus4 = i_pc + 32'd4;

  always_comb begin
    w_sel = i_pc;
    if (i_flush)
      w_sel = i_flush_addr;
    else if (i_adv)
      w_sel = i_jump_sel ? i_jump_addr : o_pc_plus4;
  end

`ifdef FETCH_MISALIGN_CHK_EN
  assign o_pc_nxt = w_sel;
`else
  assign o_pc_nxt = align_word(w_sel);
`endif

endmodule

// File: rtl/fetch.sv
// fetch: single-outstanding-request instruction fetch unit.
// Issues one word request per packet, registers the response as a packet
// for decode, holds it while stalled, then advances pc (+4 or jump).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_jump_sel, i_jump_addr      taken jump for the presented packet
//   i_flush, i_flush_addr        unconditional redirect, any state
//   i_stall                      decode not ready, hold packet
//   o_imem_req, o_imem_addr      memory request / word address
//   i_imem_valid, i_imem_rdata   memory response
//   o_valid, o_instr, o_pc, o_pc_plus4, o_misalign   packet to decode
// Macro FETCH_MISALIGN_CHK_EN: enables the misaligned-pc packet; default
// build forces alignment and ties o_misalign low.
//
// state    | meaning
// BOOT     | first cycle after reset, no request, stale responses dropped
// WAIT     | request at pc outstanding, waiting for response
// HOLD     | packet presented to decode, no request
// FLUSH    | redirected while a request was in flight, drop its response
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_jump_addr,
  input  logic        i_jump_sel,
  input  logic        i_flush,
  input  logic [31:0] i_flush_addr,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_misalign
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pkt_pc;
  logic [31:0] r_pkt_pc4;
  logic        r_misalign;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_adv;
  logic        w_mis;
  logic        w_nxt_mis;
  logic        w_wait_mis;
  logic        w_consume;

  assign w_adv     = (r_state == ST_HOLD) && !i_stall;
  assign w_consume = w_adv && !i_flush;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_mis     = (r_pc[1:0] != 2'b00);
  assign w_nxt_mis = (w_pc_nxt[1:0] != 2'b00);
`else
  assign w_mis     = 1'b0;
  assign w_nxt_mis = 1'b0;
`endif

  // A misaligned pc in WAIT never issued a request, so nothing is in flight.
  assign w_wait_mis = (r_state == ST_WAIT) && w_mis;

  fetch_pc_next u_pc_next (
    .i_pc        (r_pc),
    .i_flush     (i_flush),
    .i_flush_addr(i_flush_addr),
    .i_adv       (w_adv),
    .i_jump_sel  (i_jump_sel),
    .i_jump_addr (i_jump_addr),
    .o_pc_nxt    (w_pc_nxt),
    .o_pc_plus4  (w_pc_plus4)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      case (r_state)
        ST_WAIT:  w_state_nxt = (i_imem_valid || w_wait_mis) ? ST_WAIT : ST_FLUSH;
        ST_FLUSH: w_state_nxt = i_imem_valid ? ST_WAIT : ST_FLUSH;
        default:  w_state_nxt = ST_WAIT;
      endcase
    end else begin
      case (r_state)
        ST_BOOT:  w_state_nxt = ST_WAIT;
        ST_WAIT:  if (w_wait_mis || i_imem_valid) w_state_nxt = ST_HOLD;
        ST_HOLD:  if (!i_stall) w_state_nxt = ST_WAIT;
        ST_FLUSH: if (i_imem_valid) w_state_nxt = ST_WAIT;
        default:  w_state_nxt = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_BOOT;
`ifdef FETCH_MISALIGN_CHK_EN
      r_pc       <= RESET_VEC;
`else
      r_pc       <= align_word(RESET_VEC);
`endif
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pkt_pc   <= 32'h0;
      r_pkt_pc4  <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= (w_state_nxt == ST_WAIT) && !w_nxt_mis;
      if (i_flush || w_consume) begin
        r_valid    <= 1'b0;
        r_misalign <= 1'b0;
      end else if ((r_state == ST_WAIT) && (w_mis || i_imem_valid)) begin
        r_valid    <= 1'b1;
        r_misalign <= w_mis;
        r_instr    <= w_mis ? NOP_INSTR : i_imem_rdata;
        r_pkt_pc   <= r_pc;
        r_pkt_pc4  <= w_pc_plus4;
      end
    end
  end

  assign o_imem_req  = r_req;
  assign o_imem_addr = r_pc;
  assign o_valid     = r_valid;
  assign o_instr     = r_instr;
  assign o_pc        = r_pkt_pc;
  assign o_pc_plus4  = r_pkt_pc4;
  assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: self-checking bench for the fetch unit. Directed scenarios
// followed by a randomized run checked against a transaction-level model
// that tracks only the architectural pc sequence.
module tb_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_jump_addr;
  logic        i_jump_sel;
  logic        i_flush;
  logic [31:0] i_flush_addr;
  logic        i_stall;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_misalign;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch #(.RESET_VEC(32'h0000_0000)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_jump_addr (i_jump_addr),
    .i_jump_sel  (i_jump_sel),
    .i_flush     (i_flush),
    .i_flush_addr(i_flush_addr),
    .i_stall     (i_stall),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_valid(i_imem_valid),
    .i_imem_rdata(i_imem_rdata),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_pc_plus4  (o_pc_plus4),
    .o_misalign  (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_ctl();
    i_jump_sel   = 1'b0;
    i_flush      = 1'b0;
    i_stall      = 1'b0;
    i_imem_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_jump_addr = 32'h0; i_flush_addr = 32'h0; i_imem_rdata = 32'h0;
    clear_ctl();
    tick(); tick();
    n_total++;
    if ({o_valid, o_instr, o_pc, o_pc_plus4} !== {1'b0, NOP, 32'h0, 32'h0})
      $display("FAIL reset_pkt: got v=%0b instr=%h pc=%h pc4=%h exp v=0 instr=%h pc=0 pc4=0",
               o_valid, o_instr, o_pc, o_pc_plus4, NOP);
    else n_pass++;
    n_total++;
    if ({o_imem_req, o_imem_addr, o_misalign} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL reset_req: got req=%0b addr=%h mis=%0b exp req=0 addr=0 mis=0",
               o_imem_req, o_imem_addr, o_misalign);
    else n_pass++;
    i_rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    tick();
    n_total++;
    if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0})
      $display("FAIL boot_req: got req=%0b addr=%h exp req=1 addr=0", o_imem_req, o_imem_addr);
    else n_pass++;
    i_imem_valid = 1'b1; i_imem_rdata = 32'h0010_0093;
    tick();
    i_imem_valid = 1'b0;
    n_total++;
    if ({o_valid, o_instr, o_pc, o_pc_plus4, o_imem_req} !== {1'b1, 32'h0010_0093, 32'h0, 32'h4, 1'b0})
      $display("FAIL first_pkt: got v=%0b instr=%h pc=%h pc4=%h req=%0b exp v=1 instr=00100093 pc=0 pc4=4 req=0",
               o_valid, o_instr, o_pc, o_pc_plus4, o_imem_req);
    else n_pass++;
  endtask

  task automatic test_stall_jump();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_jump_sel = 1'b1; i_jump_addr = 32'hDEAD_0000;
      tick();
      n_total++;
      if ({o_valid, o_instr, o_pc, o_pc_plus4, o_imem_req} !== {1'b1, 32'h0010_0093, 32'h0, 32'h4, 1'b0})
        $display("FAIL stall_hold[%0d]: got v=%0b instr=%h pc=%h req=%0b exp packet held, req=0",
                 k, o_valid, o_instr, o_pc, o_imem_req);
      else n_pass++;
    end
    i_stall = 1'b0; i_jump_sel = 1'b1; i_jump_addr = 32'h0000_0100;
    tick();
    clear_ctl();
    n_total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'h0000_0100})
      $display("FAIL jump_req: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=00000100",
               o_valid, o_imem_req, o_imem_addr);
    else n_pass++;
  endtask

  task automatic test_flush_wait();
    i_flush = 1'b1; i_flush_addr = 32'h0000_0200;
    tick();
    i_flush = 1'b0;
    n_total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b0, 32'h0000_0200})
      $display("FAIL flush_enter: got v=%0b req=%0b addr=%h exp v=0 req=0 addr=00000200",
               o_valid, o_imem_req, o_imem_addr);
    else n_pass++;
    tick();
    i_imem_valid = 1'b1; i_imem_rdata = 32'hBAD0_BAD0;
    tick();
    i_imem_valid = 1'b0;
    n_total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'h0000_0200})
      $display("FAIL flush_drop: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=00000200",
               o_valid, o_imem_req, o_imem_addr);
    else n_pass++;
    tick();
    i_imem_valid = 1'b1; i_imem_rdata = 32'h0020_0113;
    tick();
    i_imem_valid = 1'b0;
    n_total++;
    if ({o_valid, o_instr, o_pc, o_pc_plus4} !== {1'b1, 32'h0020_0113, 32'h200, 32'h204})
      $display("FAIL flush_refetch: got v=%0b instr=%h pc=%h pc4=%h exp v=1 instr=00200113 pc=200 pc4=204",
               o_valid, o_instr, o_pc, o_pc_plus4);
    else n_pass++;
  endtask

  task automatic test_wrap();
    tick();
    i_flush = 1'b1; i_flush_addr = 32'hFFFF_FFFC;
    i_imem_valid = 1'b1; i_imem_rdata = 32'h1111_1111;
    tick();
    clear_ctl();
    n_total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC})
      $display("FAIL flush_with_valid: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=fffffffc",
               o_valid, o_imem_req, o_imem_addr);
    else n_pass++;
    i_imem_valid = 1'b1; i_imem_rdata = 32'h2222_2222;
    tick();
    i_imem_valid = 1'b0;
    n_total++;
    if ({o_valid, o_instr, o_pc, o_pc_plus4} !== {1'b1, 32'h2222_2222, 32'hFFFF_FFFC, 32'h0})
      $display("FAIL wrap_pkt: got v=%0b instr=%h pc=%h pc4=%h exp v=1 instr=22222222 pc=fffffffc pc4=0",
               o_valid, o_instr, o_pc, o_pc_plus4);
    else n_pass++;
    tick();
    n_total++;
    if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_req: got req=%0b addr=%h exp req=1 addr=0", o_imem_req, o_imem_addr);
    else n_pass++;
  endtask

  task automatic test_flush_over_jump();
    i_imem_valid = 1'b1; i_imem_rdata = 32'h3333_3333;
    tick();
    i_imem_valid = 1'b0;
    i_stall = 1'b1; i_flush = 1'b1; i_flush_addr = 32'h0000_0300;
    i_jump_sel = 1'b1; i_jump_addr = 32'h0000_0400;
    tick();
    clear_ctl();
    n_total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'h0000_0300})
      $display("FAIL flush_prio: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=00000300",
               o_valid, o_imem_req, o_imem_addr);
    else n_pass++;
  endtask

  task automatic test_misalign();
    i_imem_valid = 1'b1; i_imem_rdata = 32'h4444_4444;
    tick();
    i_imem_valid = 1'b0;
    i_jump_sel = 1'b1; i_jump_addr = 32'h0000_0102;
    tick();
    clear_ctl();
`ifdef FETCH_MISALIGN_CHK_EN
    n_total++;
    if ({o_imem_req, o_imem_addr} !== {1'b0, 32'h0000_0102})
      $display("FAIL mis_noreq: got req=%0b addr=%h exp req=0 addr=00000102", o_imem_req, o_imem_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({o_valid, o_misalign, o_instr, o_pc} !== {1'b1, 1'b1, NOP, 32'h0000_0102})
      $display("FAIL mis_pkt: got v=%0b mis=%0b instr=%h pc=%h exp v=1 mis=1 instr=%h pc=00000102",
               o_valid, o_misalign, o_instr, o_pc, NOP);
    else n_pass++;
    i_flush = 1'b1; i_flush_addr = 32'h0000_0400;
`else
    n_total++;
    if ({o_imem_req, o_imem_addr, o_misalign} !== {1'b1, 32'h0000_0100, 1'b0})
      $display("FAIL align_req: got req=%0b addr=%h mis=%0b exp req=1 addr=00000100 mis=0",
               o_imem_req, o_imem_addr, o_misalign);
    else n_pass++;
    i_flush = 1'b1; i_flush_addr = 32'h0000_0400;
    i_imem_valid = 1'b1; i_imem_rdata = 32'h0;
`endif
    tick();
    clear_ctl();
    n_total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'h0000_0400})
      $display("FAIL mis_recover: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=00000400",
               o_valid, o_imem_req, o_imem_addr);
    else n_pass++;
  endtask

  task automatic test_reset_midreq();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_imem_valid = 1'b1; i_imem_rdata = 32'h5555_5555;
    tick();
    i_imem_valid = 1'b0;
    n_total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL reset_stale: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=0",
               o_valid, o_imem_req, o_imem_addr);
    else n_pass++;
    m_pc = 32'h0;
  endtask

  task automatic test_random();
    logic [31:0] rd, fa, ja;
    logic        held_ok;
    int          lat, stalls, mode;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 8 && !o_imem_req; k++) tick();
      n_total++;
      if ({o_imem_req, o_imem_addr} !== {1'b1, m_pc})
        $display("FAIL rnd_req[%0d]: got req=%0b addr=%h exp req=1 addr=%h", it, o_imem_req, o_imem_addr, m_pc);
      else n_pass++;
      lat = $urandom_range(0, 3);
      held_ok = 1'b1;
      for (int k = 0; k < lat; k++) begin
        tick();
        if ({o_imem_req, o_imem_addr} !== {1'b1, m_pc}) held_ok = 1'b0;
      end
      n_total++;
      if (held_ok !== 1'b1)
        $display("FAIL rnd_req_stable[%0d]: got unstable request exp req=1 addr=%h held", it, m_pc);
      else n_pass++;
      mode = $urandom_range(0, 7);
      fa = $urandom & 32'hFFFF_FFFC;
      if (mode == 0) begin
        i_flush = 1'b1; i_flush_addr = fa;
        tick();
        i_flush = 1'b0;
        m_pc = fa;
        n_total++;
        if ({o_valid, o_imem_req} !== {1'b0, 1'b0})
          $display("FAIL rnd_flush_pend[%0d]: got v=%0b req=%0b exp v=0 req=0", it, o_valid, o_imem_req);
        else n_pass++;
        lat = $urandom_range(0, 2);
        for (int k = 0; k < lat; k++) tick();
        i_imem_valid = 1'b1; i_imem_rdata = $urandom;
        tick();
        i_imem_valid = 1'b0;
        n_total++;
        if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, m_pc})
          $display("FAIL rnd_flush_drop[%0d]: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=%h",
                   it, o_valid, o_imem_req, o_imem_addr, m_pc);
        else n_pass++;
      end else if (mode == 1) begin
        i_flush = 1'b1; i_flush_addr = fa;
        i_imem_valid = 1'b1; i_imem_rdata = $urandom;
        tick();
        clear_ctl();
        m_pc = fa;
      end else begin
        rd = $urandom;
        i_imem_valid = 1'b1; i_imem_rdata = rd;
        tick();
        i_imem_valid = 1'b0;
        n_total++;
        if ({o_valid, o_instr, o_pc, o_pc_plus4, o_misalign} !== {1'b1, rd, m_pc, m_pc + 32'd4, 1'b0})
          $display("FAIL rnd_pkt[%0d]: got v=%0b instr=%h pc=%h pc4=%h exp v=1 instr=%h pc=%h pc4=%h",
                   it, o_valid, o_instr, o_pc, o_pc_plus4, rd, m_pc, m_pc + 32'd4);
        else n_pass++;
        stalls = $urandom_range(0, 3);
        i_stall = 1'b1;
        for (int k = 0; k < stalls; k++) begin
          i_jump_sel = $urandom_range(0, 1); i_jump_addr = $urandom;
          tick();
        end
        n_total++;
        if ({o_valid, o_instr, o_pc, o_imem_req} !== {1'b1, rd, m_pc, 1'b0})
          $display("FAIL rnd_stall[%0d]: got v=%0b instr=%h pc=%h req=%0b exp v=1 instr=%h pc=%h req=0",
                   it, o_valid, o_instr, o_pc, o_imem_req, rd, m_pc);
        else n_pass++;
        ja = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        i_stall = 1'b0; i_jump_sel = $urandom_range(0, 1); i_jump_addr = ja;
        m_pc = i_jump_sel ? ja : m_pc + 32'd4;
        tick();
        clear_ctl();
        n_total++;
        if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, m_pc})
          $display("FAIL rnd_advance[%0d]: got v=%0b req=%0b addr=%h exp v=0 req=1 addr=%h",
                   it, o_valid, o_imem_req, o_imem_addr, m_pc);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_jump();
    test_flush_wait();
    test_wrap();
    test_flush_over_jump();
    test_misalign();
    test_reset_midreq();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
